// File: rtl/rsa_pkg.sv
// rsa_pkg: shared width, state encoding and counter sizing for the modexp I/O controller.
package rsa_pkg;
    localparam int RSA_W = 64;

    typedef enum logic [2:0] {LOAD, CHECK, START, WAIT, SEND, ERR} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(3 * w / 8);
    endfunction

    localparam int CNT_W = cnt_w(RSA_W);
endpackage

// File: rtl/byte_ser.sv
// byte_ser: W-bit parallel-load, MSB-first byte serializer with valid/ready.
module byte_ser #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic [7:0]   data,
    output logic         valid,
    input  logic         ready,
    output logic         done
);
    localparam int NW = $clog2(W / 8) + 1;

    logic [W-1:0]  sh;
    logic [NW-1:0] n;

    assign data  = sh[W-1 -: 8];
    assign valid = n != '0;
    assign done  = valid && ready && n == NW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh <= '0;
            n  <= '0;
        end else if (load) begin
            sh <= din;
            n  <= NW'(W / 8);
        end else if (valid && ready) begin
            sh <= {sh[W-9:0], 8'h00};
            n  <= n - NW'(1);
        end
    end
endmodule

// File: rtl/rsa_io_ctrl.sv
// rsa_io_ctrl: byte-serial operand loader and result unloader for the modexp engine,
// with N = 0 rejection and an engine run-time bound.
module rsa_io_ctrl
    import rsa_pkg::*;
#(
    parameter int W         = RSA_W,
    parameter int START_CYC = 2,
    parameter int TIMEOUT   = 1048576
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err,
    input  logic         err_clr,
    output logic [W-1:0] core_a,
    output logic [W-1:0] core_m,
    output logic [W-1:0] core_N,
    output logic         core_start_n,
    input  logic         core_ready_n,
    input  logic [W-1:0] core_result
);
    localparam int NB = 3 * W / 8;
    localparam int CW = cnt_w(W);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(START_CYC + 1);

    state_t          state, state_n;
    logic [3*W-1:0]  opr;
    logic [CW-1:0]   bcnt;
    logic [TW-1:0]   wcnt;
    logic [SW-1:0]   scnt;
    logic            in_hs, last_byte, cap, ser_done;

    // the operand shift register doubles as the engine operand registers
    assign core_a    = opr[3*W-1 -: W];
    assign core_m    = opr[2*W-1 -: W];
    assign core_N    = opr[W-1:0];
    assign in_ready  = state == LOAD;
    assign in_hs     = in_valid && in_ready;
    assign last_byte = bcnt == CW'(NB - 1);
    assign cap       = state == WAIT && wcnt != '0 && !core_ready_n;
    assign err       = state == ERR;

    always_comb begin
        state_n = state;
        case (state)
            LOAD:    if (in_hs && last_byte) state_n = CHECK;
            CHECK:   state_n = core_N == '0 ? ERR : START;
            START:   if (scnt == SW'(START_CYC - 1)) state_n = WAIT;
            WAIT:    state_n = cap ? SEND : wcnt == TW'(TIMEOUT - 1) ? ERR : WAIT;
            SEND:    if (ser_done) state_n = LOAD;
            ERR:     if (err_clr) state_n = LOAD;
            default: state_n = LOAD;
        endcase
    end

    // core_start_n resets low so the engine stays in load while we are in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            opr          <= '0;
            bcnt         <= '0;
            wcnt         <= '0;
            scnt         <= '0;
            core_start_n <= 1'b0;
        end else begin
            state        <= state_n;
            core_start_n <= state_n != START;
            if (in_hs)
                opr <= {opr[3*W-9:0], in_data};
            bcnt <= (state != LOAD || (in_hs && last_byte)) ? '0 : bcnt + CW'(in_hs);
            wcnt <= state == WAIT ? wcnt + TW'(1) : '0;
            scnt <= state == START ? scnt + SW'(1) : '0;
        end
    end

    byte_ser #(.W(W)) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (cap),
        .din   (core_result),
        .data  (out_data),
        .valid (out_valid),
        .ready (out_ready),
        .done  (ser_done)
    );
endmodule

// File: tb/tb_rsa_io_ctrl.sv
// tb_rsa_io_ctrl: table-driven vectors with a byte scoreboard and a behavioural modexp engine.
module tb_rsa_io_ctrl;
    logic        clk = 0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, err, err_clr;
    logic [7:0]  in_data, out_data;
    logic [63:0] core_a, core_m, core_N, core_result;
    logic        core_start_n, core_ready_n;

    int total = 0, bad = 0, nsent = 0;
    int mode = 0;        // 0 normal engine, 1 never ready, 2 early ready glitch
    logic throttle = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [63:0] a, m, n, res;
        logic        e;
    } vec_t;
    vec_t vecs[8];

    rsa_io_ctrl #(.W(64), .START_CYC(2), .TIMEOUT(100)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .err(err),
        .err_clr(err_clr), .core_a(core_a), .core_m(core_m), .core_N(core_N),
        .core_start_n(core_start_n), .core_ready_n(core_ready_n), .core_result(core_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] modexp(input logic [63:0] a, m, n);
        logic [127:0] r, b, nn;
        if (n == 0) return 64'd0;
        nn = {64'd0, n};
        r  = 128'd1 % nn;
        b  = {64'd0, a} % nn;
        for (int i = 0; i < 64; i++) begin
            if (m[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[63:0];
    endfunction

    // engine: ready_n low 40 cycles after the start strobe releases
    initial begin
        int ecnt = 0;
        logic started = 0, rdy, gl;
        core_ready_n = 1;
        core_result  = 64'hBAD0_BAD0_BAD0_BAD0;
        forever begin
            @(negedge clk);
            if (!core_start_n) begin
                ecnt = 0;
                started = 1;
            end else if (started && ecnt < 100000) ecnt++;
            rdy = started && core_start_n && mode != 1 && ecnt >= 40;
            gl  = mode == 2 && started && ecnt <= 1;
            core_ready_n = !(rdy || gl);
            core_result  = rdy ? modexp(core_a, core_m, core_N) : 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = throttle ? !out_ready : 1'b1;
    end

    // scoreboard monitor: pops one expected byte per output handshake
    initial begin
        logic stalled = 0;
        logic [7:0] prev = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) stalled = 0;
            else begin
                if (stalled) chk("stall_hold", {out_valid, out_data}, {1'b1, prev});
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %h expected no byte", out_data);
                    end else begin
                        chk("out_byte", out_data, exp_q.pop_front());
                        nsent++;
                    end
                end
                stalled = out_valid && !out_ready;
                prev = out_data;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic push_res(input logic [63:0] r);
        for (int i = 7; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
    endtask

    task automatic load(input logic [63:0] a, input logic [63:0] m, input logic [63:0] n);
        logic [191:0] f;
        f = {a, m, n};
        @(posedge clk);
        #1;
        for (int i = 23; i >= 0; i--) begin
            in_valid = 1;
            in_data  = f[i*8 +: 8];
            @(posedge clk);
            #1;
        end
        in_valid = 0;
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
        @(posedge clk);
        @(negedge clk);
        chk("idle", {out_valid, in_ready, err}, 3'b010);
    endtask

    task automatic clear_err();
        @(posedge clk);
        #1 err_clr = 1;
        @(posedge clk);
        #1 err_clr = 0;
        @(negedge clk);
        chk("err_clr", {err, in_ready}, 2'b01);
    endtask

    task automatic run_vec(input vec_t v);
        logic s0, s1, s2, s3, e0, e1;
        if (!v.e) push_res(v.res);
        load(v.a, v.m, v.n);
        @(negedge clk); s0 = core_start_n; e0 = err;
        @(negedge clk); s1 = core_start_n; e1 = err;
        if (!v.e) begin
            chk("core_a", core_a, v.a);
            chk("core_m", core_m, v.m);
            chk("core_N", core_N, v.n);
        end
        @(negedge clk); s2 = core_start_n;
        @(negedge clk); s3 = core_start_n;
        if (v.e) begin
            chk("err_seq", {e0, e1, s0, s1, s2, s3, in_ready, out_valid}, 8'b01_1111_00);
            @(posedge clk);
            #1 in_valid = 1;
            in_data = 8'h55;
            repeat (2) @(posedge clk);
            #1 in_valid = 0;
            chk("err_in_ready", in_ready, 0);
            clear_err();
        end else begin
            chk("start_seq", {e0, e1, s0, s1, s2, s3}, 6'b00_1001);
            drain();
        end
    endtask

    initial begin
        int n, base;
        vecs[0] = '{64'h2, 64'hA, 64'h3E8, 64'h18, 1'b0};
        vecs[1] = '{64'h3, 64'h4, 64'h7, 64'h4, 1'b0};
        vecs[2] = '{64'h1234_5678_9ABC_DEF0, 64'h1, '1, 64'h1234_5678_9ABC_DEF0, 1'b0};
        vecs[3] = '{64'h5, 64'h3, 64'h0, 64'h0, 1'b1};
        vecs[4] = '{64'h2, 64'd63, '1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[5] = '{64'h7, 64'h0, 64'h5, 64'h1, 1'b0};
        vecs[6] = '{'1, 64'h1, '1, 64'h0, 1'b0};
        vecs[7] = '{64'h0, 64'h0, 64'h1, 64'h0, 1'b0};

        rst_n = 1; in_valid = 0; in_data = 0; out_ready = 1; err_clr = 0;
        #2 rst_n = 0;
        #3;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start_n", core_start_n, 0);
        chk("rst_out", {out_valid, out_data, err}, 0);
        chk("rst_ops", core_a | core_m | core_N, 0);
        in_valid = 1;
        in_data = 8'hA5;
        repeat (3) @(posedge clk);
        #1 in_valid = 0;
        rst_n = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_release_start_n", core_start_n, 1);
        chk("rst_no_capture", core_N, 0);

        // err_clr outside ERR must be harmless
        @(posedge clk);
        #1 err_clr = 1;
        @(posedge clk);
        #1 err_clr = 0;
        @(negedge clk);
        chk("clr_outside_err", {err, in_ready}, 2'b01);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        throttle = 1;
        run_vec(vecs[0]);
        run_vec(vecs[2]);
        throttle = 0;

        // engine never answers: timeout after exactly 100 WAIT cycles
        mode = 1;
        load(vecs[1].a, vecs[1].m, vecs[1].n);
        repeat (3) @(negedge clk);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (err) break;
            n++;
        end
        chk("timeout_cycles", 64'(n), 100);
        chk("timeout_start_n", core_start_n, 1);
        clear_err();
        mode = 0;
        run_vec(vecs[1]);

        mode = 2;
        run_vec(vecs[2]);
        mode = 0;

        // reset during SEND after three bytes
        push_res(vecs[4].res);
        base = nsent;
        load(vecs[4].a, vecs[4].m, vecs[4].n);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (nsent >= base + 3) break;
        end
        chk("bytes_before_rst", 64'(nsent - base), 3);
        #1 rst_n = 0;
        #1;
        chk("mid_rst_out", {out_valid, out_data, err}, 0);
        chk("mid_rst_ops", core_a | core_m | core_N, 0);
        chk("mid_rst_ctl", {in_ready, core_start_n}, 2'b10);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        run_vec(vecs[0]);
        run_vec(vecs[6]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
